// File: rtl/bus_arb_pkg.sv
// Shared definitions for the 32-source round-robin bus arbiter.
//   N_SRC / SEL_W : fixed requester count and select-index width
//   arb_state_e   : arbiter FSM states
//   onehot()      : index -> one-hot source-enable vector
package bus_arb_pkg;

  localparam int unsigned N_SRC = 32;
  localparam int unsigned SEL_W = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RECOVER = 2'd2
  } arb_state_e;

  function automatic logic [N_SRC-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [N_SRC-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick32.sv
// Combinational round-robin picker.
//   req    : request lines
//   ptr    : highest-priority index for this search
//   winner : first requester found at ptr, ptr+1, ... (mod 32)
//   any    : at least one request present
module rr_pick32
  import bus_arb_pkg::*;
(
  input  logic [N_SRC-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] winner,
  output logic             any
);

  logic [SEL_W-1:0] idx;
  logic             found;

  // Scanning ptr+i with a 5-bit sum is the rotate / find-first / add-back
  // sequence folded into one loop; the index wraps 31 -> 0 naturally.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      idx = ptr + SEL_W'(i);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
    any = |req;
  end

endmodule

// File: rtl/bus_arbiter_rr32.sv
// Round-robin arbiter for the shared 32-source internal bus.
//   clock     : system clock, rising edge
//   clear     : asynchronous active-low reset
//   req       : level-sensitive request lines
//   grant     : one-hot bus-drive enable, zero when no owner
//   bus_sel   : index of the current or last owner
//   bus_valid : high while grant is non-zero
//   timeout   : one-cycle pulse during the RECOVER cycle after preemption
// One dead RECOVER cycle separates owners; an owner is preempted after
// MAX_HOLD consecutive GRANT cycles (MAX_HOLD = 0 disables preemption).
module bus_arbiter_rr32
  import bus_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [N_SRC-1:0] req,
  output logic [N_SRC-1:0] grant,
  output logic [SEL_W-1:0] bus_sel,
  output logic             bus_valid,
  output logic             timeout
);

  localparam int unsigned     HC_W      = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam int unsigned     LAST_INT  = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(LAST_INT);

  arb_state_e       state_q, state_d;
  logic [SEL_W-1:0] owner_q, owner_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [HC_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [N_SRC-1:0] grant_q, grant_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;

  logic [SEL_W-1:0] pick_winner;
  logic             pick_any;

  rr_pick32 u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .winner (pick_winner),
    .any    (pick_any)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;

    unique case (state_q)
      IDLE, RECOVER: begin
        if (pick_any) begin
          state_d    = GRANT;
          owner_d    = pick_winner;
          hold_cnt_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        // Release takes precedence over preemption, so a coincident drop
        // never raises timeout.
        if (!req[owner_q]) begin
          state_d = RECOVER;
          ptr_d   = owner_q + 1'b1;
        end else if ((MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST)) begin
          state_d   = RECOVER;
          ptr_d     = owner_q + 1'b1;
          timeout_d = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next-state values, so each flop
    // mirrors what a decode of state_q/owner_q would give, without decode glitches.
    valid_d = (state_d == GRANT);
    grant_d = valid_d ? onehot(owner_d) : '0;
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
      grant_q    <= '0;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      grant_q    <= grant_d;
      valid_q    <= valid_d;
      timeout_q  <= timeout_d;
    end
  end

  assign grant     = grant_q;
  assign bus_valid = valid_q;
  assign bus_sel   = owner_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_bus_arbiter_rr32.sv
module tb_bus_arbiter_rr32;

  logic        clock;
  logic        clear;
  logic [31:0] req;
  logic [31:0] grant;
  logic [4:0]  bus_sel;
  logic        bus_valid;
  logic        timeout;

  int checks;
  int failures;

  typedef struct {
    logic [4:0]  owner;
    int unsigned len;
    logic        to;
  } exp_t;

  exp_t sb[$];

  bus_arbiter_rr32 #(.MAX_HOLD(16)) dut (
    .clock     (clock),
    .clear     (clear),
    .req       (req),
    .grant     (grant),
    .bus_sel   (bus_sel),
    .bus_valid (bus_valid),
    .timeout   (timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [4:0] o, input int unsigned l, input logic t);
    exp_t e;
    e.owner = o;
    e.len   = l;
    e.to    = t;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    @(posedge clock);
    #2 clear = 1'b0;
    req = '0;
    step(2);
    clear = 1'b1;
  endtask

  // Monitor: measures each ownership interval and checks it against the
  // scoreboard in the dead cycle that follows it.
  logic        prev_valid;
  int unsigned run_len;
  logic [4:0]  cap_sel;
  logic [31:0] cap_grant;

  initial begin
    prev_valid = 1'b0;
    run_len    = 0;
    cap_sel    = '0;
    cap_grant  = '0;
  end

  always @(negedge clock) begin
    exp_t e;
    logic [31:0] one;
    if (!clear) begin
      prev_valid = 1'b0;
    end else begin
      chk("grant_onehot0", {31'd0, $onehot0(grant)}, 32'd1);
      if (bus_valid) begin
        chk("timeout_in_grant", {31'd0, timeout}, 32'd0);
        if (!prev_valid) begin
          run_len   = 1;
          cap_sel   = bus_sel;
          cap_grant = grant;
        end else begin
          run_len++;
        end
      end else if (prev_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_grant", {27'd0, cap_sel}, 32'hFFFF_FFFF);
        end else begin
          e   = sb.pop_front();
          one = 32'd1 << e.owner;
          chk("owner_sel",    {27'd0, cap_sel}, {27'd0, e.owner});
          chk("owner_grant",  cap_grant, one);
          chk("hold_len",     run_len, e.len);
          chk("recover_to",   {31'd0, timeout}, {31'd0, e.to});
          chk("recover_dead", grant, 32'd0);
        end
      end
      prev_valid = bus_valid;
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    clear    = 1'b0;
    req      = '0;

    // Reset values while clear is held low
    repeat (3) begin
      @(negedge clock);
      chk("rst_grant",   grant, 32'd0);
      chk("rst_sel",     {27'd0, bus_sel}, 32'd0);
      chk("rst_valid",   {31'd0, bus_valid}, 32'd0);
      chk("rst_timeout", {31'd0, timeout}, 32'd0);
    end
    @(posedge clock);
    #1 clear = 1'b1;

    // Single request: one-cycle latency, owner 4 for 3 cycles
    push(5'd4, 3, 1'b0);
    req = 32'h0000_0010;
    chk("lat_before", grant, 32'd0);
    step(1);
    chk("lat_grant", grant, 32'h10);
    chk("lat_sel",   {27'd0, bus_sel}, 32'd4);
    chk("lat_valid", {31'd0, bus_valid}, 32'd1);
    step(2);
    req = '0;
    step(3);
    chk("idle_sel_hold", {27'd0, bus_sel}, 32'd4);

    // Round robin with ptr wrap 31 -> 0
    do_reset();
    push(5'd0, 2, 1'b0);
    push(5'd1, 2, 1'b0);
    push(5'd31, 2, 1'b0);
    push(5'd0, 2, 1'b0);
    req = 32'h8000_0003;
    step(1);
    begin
      int order[3];
      order = '{0, 1, 31};
      for (int k = 0; k < 3; k++) begin
        step(1);
        req[order[k]] = 1'b0;
        step(1);
        req[order[k]] = 1'b1;
        step(1);
      end
    end
    step(1);
    req = '0;
    step(3);

    // Preemption of owner 5 in favour of 6
    do_reset();
    push(5'd5, 16, 1'b1);
    push(5'd6, 2, 1'b0);
    req = 32'h0000_0020;
    step(3);
    req = 32'h0000_0060;
    step(16);
    chk("preempt_sel", {27'd0, bus_sel}, 32'd6);
    req = '0;
    step(3);

    // Lone hog re-granted after each preemption
    do_reset();
    push(5'd9, 16, 1'b1);
    push(5'd9, 16, 1'b1);
    push(5'd9, 2, 1'b0);
    req = 32'h0000_0200;
    step(36);
    req = '0;
    step(3);

    // Asynchronous reset in the middle of a grant
    do_reset();
    req = 32'h0000_1000;
    step(3);
    chk("mid_pre_grant", grant, 32'h1000);
    #2 clear = 1'b0;
    #1;
    chk("async_grant",   grant, 32'd0);
    chk("async_valid",   {31'd0, bus_valid}, 32'd0);
    chk("async_sel",     {27'd0, bus_sel}, 32'd0);
    chk("async_timeout", {31'd0, timeout}, 32'd0);
    push(5'd3, 2, 1'b0);
    req = 32'h0000_1008;
    step(2);
    clear = 1'b1;
    step(1);
    chk("post_rst_grant", grant, 32'h8);
    step(1);
    req = '0;
    step(3);

    // Release on the same edge the hold limit is reached
    do_reset();
    push(5'd2, 16, 1'b0);
    req = 32'h0000_0004;
    step(16);
    req = '0;
    step(4);

    chk("sb_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_rr32.md
Name: bus_arbiter_rr32

Overview:
- Round-robin arbiter for the shared 32-source internal bus.
- Grants exactly one requester at a time.
- Drives the one-hot source-enable vector and the 5-bit select index to the bus multiplexer.
- Inserts one dead (turnaround) cycle between owners.
- Preempts any owner that holds the bus longer than MAX_HOLD cycles.

Parameters:
- N_SRC, 32, number of bus requesters (fixed at 32 for this design).
- SEL_W, 5, width of the encoded select index.
- MAX_HOLD, 16, maximum consecutive GRANT cycles per owner; 0 disables preemption; legal values 0 or >= 2.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- clear  in  1  asynchronous, active-low reset.
- req  in  32  request lines; bit i set = source i wants the bus; level-sensitive.
- grant  out  32  one-hot bus-drive enable; all zero when no owner.
- bus_sel  out  5  index of the current or last owner.
- bus_valid  out  1  high only while grant is non-zero.
- timeout  out  1  one-cycle pulse when an owner is preempted.

Behaviour:
- State register: IDLE, GRANT, RECOVER.
- Other registers:
  - owner[4:0]
  - ptr[4:0] (highest-priority index)
  - hold_cnt[clog2(MAX_HOLD)-1:0]
- clear low, asynchronously:
  - state = IDLE; owner = 0; ptr = 0; hold_cnt = 0.
  - Outputs: grant = 0, bus_sel = 0, bus_valid = 0, timeout = 0.
  - Applies mid-grant as well: grant drops with no clock edge required.
- All outputs are decoded only from registers; no combinational path from req to any output.
  - grant = (state == GRANT) ? (1 << owner) : 0.
  - bus_valid = (state == GRANT).
  - bus_sel = owner, which holds its value through RECOVER and IDLE.
- Arbitration happens in IDLE and RECOVER only.
  - winner = first set bit of req searching ptr, ptr+1, ..., 31, 0, ..., ptr-1 (mod 32).
  - If req != 0: next state = GRANT, owner = winner, hold_cnt = 0.
  - If req == 0: RECOVER goes to IDLE; IDLE stays in IDLE.
- Latency: req sampled at edge k in IDLE gives grant high at cycle k+1.
- GRANT, evaluated at each edge:
  - req[owner] == 0: next state RECOVER; ptr = owner+1 (wraps 31 -> 0).
  - Else if MAX_HOLD != 0 and hold_cnt == MAX_HOLD-1: next state RECOVER; ptr = owner+1; timeout = 1 for the RECOVER cycle.
  - Else: stay in GRANT; hold_cnt += 1.
- Owner hold: an owner keeping req high holds the bus for exactly MAX_HOLD cycles.
- Other requesters' req changes during GRANT are ignored.
- RECOVER lasts exactly one cycle, with grant = 0 (bus turnaround). A new owner is granted in the following cycle.
- A released or preempted owner that still requests has the lowest priority, because ptr has advanced past it.
- If the preempted owner is the only requester, it is re-granted after the single RECOVER cycle.
- Simultaneous events:
  - req[owner] drop and timeout on the same edge: treat as release; timeout stays 0.
- Glitch-free: grant never has more than one bit set, including across reset release.

Decomposition:
- Shared package bus_arb_pkg:
  - state enum {IDLE, GRANT, RECOVER}
  - constants N_SRC = 32, SEL_W = 5
  - function onehot(idx)
- One sub-module, rr_pick32. Purely combinational:
  - Inputs: req[31:0], ptr[4:0].
  - Outputs: winner[4:0], any.
  - Rotate by ptr, fixed-priority find-first, add ptr back mod 32.
- Top module holds the FSM, counters and output registers.

Test Plan:
- Reset then single request:
  - Stimulus: clear low for 3 cycles, then high; req = 32'h0000_0010 held.
  - Response: all outputs 0 during clear. One cycle after req sampled: grant = 32'h10, bus_sel = 4, bus_valid = 1.
- Round-robin fairness:
  - Stimulus: req = 32'h8000_0003, each owner drops its own bit after 2 cycles, then re-raises it.
  - Response: grant order 0, 1, 31, 0. One RECOVER cycle (grant = 0) between each. Wrap of ptr 31 -> 0 verified.
- Timeout preemption (MAX_HOLD = 16):
  - Stimulus: req[5] held forever; req[6] raised at cycle 3.
  - Response: grant[5] high for exactly 16 cycles; timeout pulses once; one dead cycle; grant = 32'h40, bus_sel = 6.
- Lone hog:
  - Stimulus: only req[9] held continuously.
  - Response: repeating pattern of 16 GRANT cycles, 1 RECOVER cycle with timeout = 1; bus_sel stays 9.
- Async reset mid-grant:
  - Stimulus: owner 12 granted; clear driven low between clock edges.
  - Response: grant = 0 and bus_valid = 0 immediately. After release, with req[12] and req[3] set: first grant goes to 3, since ptr reset to 0.
- Release/timeout coincidence:
  - Stimulus: req[owner] drops on the edge where hold_cnt == 15.
  - Response: RECOVER entered with timeout = 0.
